// File: rtl/ahb_master_ctrl.sv
// ahb_master_ctrl: arbitrates the fetch and load/store requesters onto a single
// AHB-Lite bus. It runs one non-pipelined transfer at a time, checks region and
// alignment locally before touching the bus, and returns extended load data or
// an error flag to the requester that won arbitration.
module ahb_master_ctrl #(
    parameter logic [7:0] ROM_REGION = 8'hA0,
    parameter logic [7:0] RAM_REGION = 8'hB0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_func3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata
);
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR, ST_DONE} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_reg, state_next;
    logic [1:0]  htrans_reg, htrans_next;
    logic [31:0] haddr_reg, haddr_next;
    logic        hwrite_reg, hwrite_next;
    logic [2:0]  hsize_reg, hsize_next;
    logic [3:0]  hprot_reg, hprot_next;
    logic [31:0] hwdata_reg, hwdata_next;
    logic [2:0]  func3_reg, func3_next;
    logic        grant_ls_reg, grant_ls_next;     // owner of the current transfer: 1 = LSU
    logic        last_grant_reg, last_grant_next; // previous winner: 1 = LSU, 0 = fetch
    logic        err_reg, err_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] ls_rdata_reg, ls_rdata_next;

    // Round-robin: on a tie the requester that did not win last time goes first.
    logic pick_ls, pick_if;
    assign pick_ls = ls_req && (!if_req || !last_grant_reg);
    assign pick_if = if_req && !pick_ls;

    // Payload of whichever requester is being granted this cycle.
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [2:0]  sel_func3;
    logic [2:0]  sel_size;
    logic [3:0]  sel_prot;
    logic [31:0] sel_wdata;
    logic [31:0] lane_wdata;

    assign sel_addr  = pick_ls ? ls_addr : if_addr;
    assign sel_we    = pick_ls && ls_we;
    assign sel_func3 = pick_ls ? ls_func3 : 3'b010;
    assign sel_size  = sel_func3[1] ? 3'b010 : (sel_func3[0] ? 3'b001 : 3'b000);
    assign sel_prot  = pick_ls ? 4'b0001 : 4'b0000;

    // Replicate narrow store data across every byte lane so the slave can pick any lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            assign lane_wdata[gi*8 +: 8] = (sel_size == 3'b000) ? ls_wdata[7:0] :
                                           (sel_size == 3'b001) ? ls_wdata[(gi%2)*8 +: 8] :
                                                                  ls_wdata[gi*8 +: 8];
        end
    endgenerate
    assign sel_wdata = pick_ls ? lane_wdata : 32'h0;

    // Requests that can never succeed are answered locally without a bus cycle.
    logic is_rom, is_ram, misaligned, local_fail;
    assign is_rom     = (sel_addr[31:24] == ROM_REGION);
    assign is_ram     = (sel_addr[31:24] == RAM_REGION);
    assign misaligned = ((sel_size == 3'b001) && sel_addr[0]) ||
                        ((sel_size == 3'b010) && (sel_addr[1:0] != 2'b00));
    assign local_fail = (!is_rom && !is_ram) || (sel_we && is_rom) || misaligned;

    // Load extraction: pick the addressed lane and extend it per func3.
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    assign lane_byte = hrdata[{haddr_reg[1:0], 3'b000} +: 8];
    assign lane_half = hrdata[{haddr_reg[1], 4'b0000} +: 16];

    // Sign/zero extension of the selected lane.
    always_comb begin
        case (func3_reg)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'h0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'h0, lane_half};
            default: load_data = hrdata;
        endcase
    end

    logic        finish;
    logic [31:0] finish_rdata;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_next      = state_reg;
        htrans_next     = htrans_reg;
        haddr_next      = haddr_reg;
        hwrite_next     = hwrite_reg;
        hsize_next      = hsize_reg;
        hprot_next      = hprot_reg;
        hwdata_next     = hwdata_reg;
        func3_next      = func3_reg;
        grant_ls_next   = grant_ls_reg;
        last_grant_next = last_grant_reg;
        err_next        = err_reg;
        if_rdata_next   = if_rdata_reg;
        ls_rdata_next   = ls_rdata_reg;
        finish          = 1'b0;
        finish_rdata    = 32'h0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_ls || pick_if) begin
                    grant_ls_next   = pick_ls;
                    last_grant_next = pick_ls;
                    if (local_fail) begin
                        state_next = ST_DONE;
                        err_next   = 1'b1;
                        finish     = 1'b1;
                    end else begin
                        state_next  = ST_ADDR;
                        htrans_next = HTRANS_NONSEQ;
                        haddr_next  = sel_addr;
                        hwrite_next = sel_we;
                        hsize_next  = sel_size;
                        hprot_next  = sel_prot;
                        hwdata_next = sel_wdata;
                        func3_next  = sel_func3;
                        err_next    = 1'b0;
                    end
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    state_next  = ST_DATA;
                    htrans_next = HTRANS_IDLE;
                end
            end
            ST_DATA: begin
                if (hresp) begin
                    if (hready) begin
                        // Single-cycle ERROR is a slave protocol violation; fail immediately.
                        state_next = ST_DONE;
                        err_next   = 1'b1;
                        finish     = 1'b1;
                    end else begin
                        state_next = ST_ERR;
                    end
                end else if (hready) begin
                    state_next   = ST_DONE;
                    err_next     = 1'b0;
                    finish       = 1'b1;
                    finish_rdata = hwrite_reg ? 32'h0 : load_data;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                    finish     = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (finish) begin
            if (grant_ls_next) begin
                ls_rdata_next = finish_rdata;
            end else begin
                if_rdata_next = finish_rdata;
            end
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg      <= ST_IDLE;
            htrans_reg     <= HTRANS_IDLE;
            haddr_reg      <= 32'h0;
            hwrite_reg     <= 1'b0;
            hsize_reg      <= 3'b010;
            hprot_reg      <= 4'b0000;
            hwdata_reg     <= 32'h0;
            func3_reg      <= 3'b010;
            grant_ls_reg   <= 1'b0;
            last_grant_reg <= 1'b0;
            err_reg        <= 1'b0;
            if_rdata_reg   <= 32'h0;
            ls_rdata_reg   <= 32'h0;
        end else begin
            state_reg      <= state_next;
            htrans_reg     <= htrans_next;
            haddr_reg      <= haddr_next;
            hwrite_reg     <= hwrite_next;
            hsize_reg      <= hsize_next;
            hprot_reg      <= hprot_next;
            hwdata_reg     <= hwdata_next;
            func3_reg      <= func3_next;
            grant_ls_reg   <= grant_ls_next;
            last_grant_reg <= last_grant_next;
            err_reg        <= err_next;
            if_rdata_reg   <= if_rdata_next;
            ls_rdata_reg   <= ls_rdata_next;
        end
    end

    assign htrans   = htrans_reg;
    assign haddr    = haddr_reg;
    assign hwrite   = hwrite_reg;
    assign hsize    = hsize_reg;
    assign hprot    = hprot_reg;
    assign hwdata   = hwdata_reg;
    assign if_done  = (state_reg == ST_DONE) && !grant_ls_reg;
    assign ls_done  = (state_reg == ST_DONE) && grant_ls_reg;
    assign if_err   = if_done && err_reg;
    assign ls_err   = ls_done && err_reg;
    assign if_rdata = if_rdata_reg;
    assign ls_rdata = ls_rdata_reg;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Testbench for ahb_master_ctrl: a transaction-level model predicts, cycle by
// cycle, the bus phases, done pulses and returned data; one negedge process
// compares the DUT against it. Directed cases pin the model with literals.
module tb_ahb_master_ctrl;
    logic        hclk = 1'b0;
    logic        hreset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done, if_err;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [2:0]  ls_func3;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;

    ahb_master_ctrl dut (
        .hclk(hclk), .hreset(hreset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_func3(ls_func3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata)
    );

    always #5 hclk = ~hclk;

    localparam int K_OK = 0, K_ERR = 1, K_VIOL = 2;

    int vectors = 0;
    int miscompares = 0;
    int txn_cyc = 0;
    int txn_no = 0;

    // model state and per-cycle expectations
    bit          last_ls = 1'b0;
    logic [1:0]  exp_htrans = 2'b00;
    bit          exp_if_done = 0, exp_ls_done = 0, exp_if_err = 0, exp_ls_err = 0;
    logic [31:0] exp_if_rdata = 32'h0, exp_ls_rdata = 32'h0;
    bit          exp_addr_phase = 0, exp_data_phase = 0;
    logic [31:0] exp_haddr = 32'h0, exp_hwdata = 32'h0;
    logic        exp_hwrite = 1'b0;
    logic [2:0]  exp_hsize = 3'b010;
    logic [3:0]  exp_hprot = 4'h0;

    // observations for literal pins
    int          seen_lat = -1;
    bit          seen_ls = 0, seen_err = 0;
    logic [2:0]  snap_hsize;
    logic        snap_hwrite;
    logic [3:0]  snap_hprot;
    logic [31:0] snap_hwdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (txn %0d, cycle %0d)", name, act, exp, txn_no, txn_cyc);
        end
    endtask

    function automatic int m_nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [2:0] m_size(input logic [2:0] f3);
        return 3'($clog2(m_nbytes(f3)));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = m_nbytes(f3);
        if (n == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = m_nbytes(f3);
        logic [31:0] mask, v;
        if (n == 4) return rd;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rd >> (8 * a[1:0])) & mask;
        if (!f3[2] && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_ok(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (a[31:24] != 8'hA0 && a[31:24] != 8'hB0) return 0;
        if (we && a[31:24] == 8'hA0) return 0;
        if ((int'(a[1:0]) % m_nbytes(f3)) != 0) return 0;
        return 1;
    endfunction

    // single compare process
    always @(negedge hclk) begin
        chk("htrans", 32'(htrans), 32'(exp_htrans));
        chk("if_done", 32'(if_done), 32'(exp_if_done));
        chk("ls_done", 32'(ls_done), 32'(exp_ls_done));
        if (exp_if_done) chk("if_err", 32'(if_err), 32'(exp_if_err));
        if (exp_ls_done) chk("ls_err", 32'(ls_err), 32'(exp_ls_err));
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("ls_rdata", ls_rdata, exp_ls_rdata);
        if (exp_addr_phase) begin
            chk("haddr", haddr, exp_haddr);
            chk("hwrite", 32'(hwrite), 32'(exp_hwrite));
            chk("hsize", 32'(hsize), 32'(exp_hsize));
            chk("hprot", 32'(hprot), 32'(exp_hprot));
            if (exp_hwrite) chk("hwdata_addr", hwdata, exp_hwdata);
        end
        if (exp_data_phase && exp_hwrite) chk("hwdata_data", hwdata, exp_hwdata);
        if (htrans == 2'b10) begin
            snap_hsize  = hsize;
            snap_hwrite = hwrite;
            snap_hprot  = hprot;
        end
        if (exp_data_phase) snap_hwdata = hwdata;
        if (if_done || ls_done) begin
            seen_lat = txn_cyc;
            seen_ls  = ls_done;
            seen_err = ls_done ? ls_err : if_err;
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
        txn_cyc++;
    endtask

    // Run one transfer for whichever requester the model says wins arbitration.
    task automatic serve(input int aw, input int dw, input int kind, input int ew, input logic [31:0] rd);
        bit win_ls, ok, we, err;
        logic [2:0]  f3;
        logic [31:0] a, wd, res;
        win_ls  = ls_req && (!if_req || !last_ls);
        last_ls = win_ls;
        if (win_ls) begin a = ls_addr; we = ls_we; f3 = ls_func3; wd = ls_wdata; end
        else        begin a = if_addr; we = 1'b0;  f3 = 3'b010;   wd = 32'h0;    end
        ok = m_ok(we, f3, a);
        txn_cyc = 0;
        seen_lat = -1;
        err = 1'b1;
        res = 32'h0;
        if (ok) begin
            exp_haddr  = a;
            exp_hwrite = we;
            exp_hsize  = m_size(f3);
            exp_hprot  = win_ls ? 4'b0001 : 4'b0000;
            exp_hwdata = m_wdata(f3, wd);
            for (int i = 0; i <= aw; i++) begin
                step();
                exp_htrans = 2'b10; exp_addr_phase = 1;
                hready = (i == aw); hresp = 0; hrdata = $urandom;
            end
            for (int i = 0; i < dw; i++) begin
                step();
                exp_htrans = 2'b00; exp_addr_phase = 0; exp_data_phase = 1;
                hready = 0; hresp = 0; hrdata = $urandom;
            end
            step();
            exp_htrans = 2'b00; exp_addr_phase = 0; exp_data_phase = 1;
            if (kind == K_OK) begin
                hready = 1; hresp = 0; hrdata = rd;
                err = 1'b0;
                res = we ? 32'h0 : m_load(f3, a, rd);
            end else if (kind == K_VIOL) begin
                hready = 1; hresp = 1;
            end else begin
                hready = 0; hresp = 1;
                for (int i = 0; i <= ew; i++) begin
                    step();
                    exp_data_phase = 0;
                    hready = (i == ew); hresp = 1;
                end
            end
        end
        step();
        exp_addr_phase = 0; exp_data_phase = 0;
        hready = 1; hresp = 0;
        if (win_ls) begin
            exp_ls_done = 1; exp_ls_err = err; exp_ls_rdata = res; ls_req = 0;
        end else begin
            exp_if_done = 1; exp_if_err = err; exp_if_rdata = res; if_req = 0;
        end
        $display("txn %0d: %s addr=%h we=%0d f3=%0d waits=%0d/%0d kind=%0d err=%0d rdata=%h",
                 txn_no, win_ls ? "ls" : "if", a, we, f3, aw, dw, kind, err, res);
        txn_no++;
        step();
        exp_if_done = 0; exp_ls_done = 0;
    endtask

    task automatic set_if(input logic [31:0] a);
        if_req = 1; if_addr = a;
    endtask

    task automatic set_ls(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        ls_req = 1; ls_we = we; ls_func3 = f3; ls_addr = a; ls_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr(input int nbytes);
        logic [31:0] a;
        int r;
        a = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0)      a[31:24] = 8'hC0;
        else if (r == 1) a[31:24] = 8'($urandom_range(0, 255));
        else if (r < 6)  a[31:24] = 8'hA0;
        else             a[31:24] = 8'hB0;
        if ($urandom_range(0, 3) != 0) begin
            if (nbytes == 4) a[1:0] = 2'b00;
            else if (nbytes == 2) a[0] = 1'b0;
        end
        return a;
    endfunction

    task automatic new_ls();
        logic [2:0] f3s [8];
        logic [2:0] f3;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        f3 = f3s[$urandom_range(0, 7)];
        set_ls($urandom_range(0, 2) == 0, f3, rand_addr(m_nbytes(f3)), $urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, kind;
        hreset = 1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_func3 = 0;
        ls_addr = 0; ls_wdata = 0; hready = 1; hresp = 0; hrdata = 0;
        #2;
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_hwrite", 32'(hwrite), 32'h0);
        chk("rst_hsize", 32'(hsize), 32'h2);
        chk("rst_hprot", 32'(hprot), 32'h0);
        chk("rst_done", 32'({if_done, ls_done, if_err, ls_err}), 32'h0);
        repeat (2) @(posedge hclk);
        #3 hreset = 0;
        step();

        // tie twice in a row: LSU first, then fetch
        for (int k = 0; k < 2; k++) begin
            set_if(32'hA000_0020 + 32'(k * 4));
            set_ls(0, 3'b010, 32'hB000_0040, 32'h0);
            serve(0, 0, K_OK, 0, 32'h1111_2222 + 32'(k));
            chk("tie_first_ls", 32'(seen_ls), 32'h1);
            serve(0, 0, K_OK, 0, 32'h3333_4444 + 32'(k));
            chk("tie_second_if", 32'(seen_ls), 32'h0);
        end

        // zero-wait fetch
        set_if(32'hA000_0010);
        serve(0, 0, K_OK, 0, 32'h1234_5678);
        chk("fetch_lat", 32'(seen_lat), 32'd3);
        chk("fetch_rdata", if_rdata, 32'h1234_5678);
        chk("fetch_err", 32'(seen_err), 32'h0);
        chk("fetch_hsize", 32'(snap_hsize), 32'h2);
        chk("fetch_hprot", 32'(snap_hprot), 32'h0);

        // LB / LBU
        set_ls(0, 3'b000, 32'hB000_0003, 32'h0);
        serve(0, 0, K_OK, 0, 32'h80FF_FFFF);
        chk("lb_rdata", ls_rdata, 32'hFFFF_FF80);
        set_ls(0, 3'b100, 32'hB000_0003, 32'h0);
        serve(0, 0, K_OK, 0, 32'h80FF_FFFF);
        chk("lbu_rdata", ls_rdata, 32'h0000_0080);

        // SH with two data wait states
        set_ls(1, 3'b001, 32'hB000_0002, 32'h0000_ABCD);
        serve(0, 2, K_OK, 0, 32'hDEAD_BEEF);
        chk("sh_lat", 32'(seen_lat), 32'd5);
        chk("sh_hwdata", snap_hwdata, 32'hABCD_ABCD);
        chk("sh_hsize", 32'(snap_hsize), 32'h1);
        chk("sh_hwrite", 32'(snap_hwrite), 32'h1);
        chk("sh_rdata", ls_rdata, 32'h0);

        // two-cycle ERROR response
        set_ls(0, 3'b010, 32'hB000_0100, 32'h0);
        serve(0, 0, K_ERR, 0, 32'h0);
        chk("buserr_lat", 32'(seen_lat), 32'd4);
        chk("buserr_err", 32'(seen_err), 32'h1);

        // local rejections
        set_ls(1, 3'b010, 32'hA000_0000, 32'h5555_5555);
        serve(0, 0, K_OK, 0, 32'h0);
        chk("rom_store_lat", 32'(seen_lat), 32'd1);
        chk("rom_store_err", 32'(seen_err), 32'h1);
        set_ls(0, 3'b010, 32'hC000_0000, 32'h0);
        serve(0, 0, K_OK, 0, 32'h0);
        chk("bad_region_lat", 32'(seen_lat), 32'd1);
        chk("bad_region_err", 32'(seen_err), 32'h1);
        set_ls(0, 3'b010, 32'hB000_0002, 32'h0);
        serve(0, 0, K_OK, 0, 32'h0);
        chk("misalign_lat", 32'(seen_lat), 32'd1);
        chk("misalign_err", 32'(seen_err), 32'h1);

        // reset during the data phase
        set_if(32'hA000_0040);
        last_ls = 0;
        txn_cyc = 0;
        step();
        exp_htrans = 2'b10; exp_addr_phase = 1; exp_haddr = 32'hA000_0040;
        exp_hwrite = 0; exp_hsize = 3'b010; exp_hprot = 4'h0; hready = 1;
        step();
        exp_htrans = 2'b00; exp_addr_phase = 0; exp_data_phase = 1; hready = 0;
        step();
        #2;
        hreset = 1; if_req = 0;
        exp_data_phase = 0; exp_if_rdata = 32'h0; exp_ls_rdata = 32'h0; last_ls = 0;
        #1;
        chk("mid_rst_htrans", 32'(htrans), 32'h0);
        chk("mid_rst_haddr", haddr, 32'h0);
        chk("mid_rst_hsize", 32'(hsize), 32'h2);
        chk("mid_rst_if_rdata", if_rdata, 32'h0);
        chk("mid_rst_done", 32'({if_done, ls_done}), 32'h0);
        step();
        step();
        #2 hreset = 0; hready = 1;
        repeat (4) step();

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            if (!if_req && !ls_req) begin
                r = $urandom_range(0, 2);
                if (r != 1) set_if(rand_addr(4));
                if (r != 0) new_ls();
            end else if ($urandom_range(0, 1) == 1) begin
                if (!if_req) set_if(rand_addr(4));
                else if (!ls_req) new_ls();
            end
            r = $urandom_range(0, 9);
            kind = (r == 0) ? K_VIOL : (r == 1) ? K_ERR : K_OK;
            serve($urandom_range(0, 2), $urandom_range(0, 3), kind, $urandom_range(0, 2), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_master_ctrl.md
# ahb_master_ctrl

Sequential AHB-Lite master controller between the core's two memory requesters (instruction fetch and load/store unit) and the single AHB bus. It arbitrates the requesters and decodes the ROM/RAM region. It drives one non-pipelined transfer at a time through address and data phases, including wait states and the two-cycle ERROR response. It returns extended load data or an error flag to the winning requester.

## Interface

- ROM_REGION, 8'hA0, haddr[31:24] value selecting ROM (read-only)
- RAM_REGION, 8'hB0, haddr[31:24] value selecting RAM (read/write)

- hclk  in  1  bus clock, all state on rising edge
- hreset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  32  fetch address (word access)
- if_done  out  1  one-cycle completion pulse to fetch
- if_err  out  1  valid with if_done; transfer failed
- if_rdata  out  32  fetched word, valid with if_done
- ls_req  in  1  LSU request; payload stable until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_func3  in  3  RV32 width/sign code
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data, right-aligned
- ls_done  out  1  one-cycle completion pulse to LSU
- ls_err  out  1  valid with ls_done
- ls_rdata  out  32  sign/zero-extended load data
- hready  in  1  AHB transfer ready
- hresp  in  1  AHB response, 1 = ERROR
- hrdata  in  32  AHB read data
- htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
- haddr, hwrite, hsize[2:0], hprot[3:0], hwdata[31:0]  out  AHB address/control/write data

## Operation

- States: IDLE, ADDR, DATA, ERR, DONE. All bus outputs are registered.
- IDLE arbitration:
  - One requester: that requester wins.
  - Both requesting: round-robin on a last_grant flag. last_grant resets to fetch, so the LSU wins the first tie.
- Payload is latched at grant. Fetch uses func3 = 3'b010, write = 0, hprot = 4'b0000. LSU uses hprot = 4'b0001.
- Local checks at grant. A failure skips the bus and goes IDLE -> DONE with err = 1. Failures:
  - Region is neither ROM_REGION nor RAM_REGION.
  - Store to ROM.
  - Misaligned address: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- hsize: func3 000/100 -> 3'b000; 001/101 -> 3'b001; others -> 3'b010.
- hwdata: byte replicated to all 4 lanes, halfword to both halves, word as is.
- Load extraction:
  - Select lane by haddr[1:0].
  - func3 000 sign-extends a byte, 100 zero-extends a byte.
  - func3 001 sign-extends a halfword, 101 zero-extends a halfword.
  - Otherwise the full word is returned.
- ADDR: htrans = NONSEQ with haddr/hwrite/hsize/hprot valid. Hold until hready = 1 is sampled, then go to DATA.
- DATA: htrans = IDLE. Keep hwdata valid; haddr/control may hold.
  - hready = 0, hresp = 0: wait in DATA.
  - hready = 1, hresp = 0: capture hrdata and go to DONE with err = 0.
  - hready = 0, hresp = 1: go to ERR.
  - hready = 1, hresp = 1 (protocol violation): go to DONE with err = 1.
- ERR: htrans stays IDLE. Wait for hready = 1, then go to DONE with err = 1.
- DONE: pulse the granted port's done/err for exactly one cycle with rdata valid, then return to IDLE.
  - rdata holds until that port's next done.
  - Stores return rdata = 0.
- Reset values:
  - htrans 00, haddr 0, hwdata 0, hwrite 0, hsize 3'b010, hprot 0.
  - All done/err 0, both rdata 0, state IDLE, last_grant = fetch.
- Reset mid-transfer: immediate return to IDLE with reset values. No done pulse; the transfer is dropped.

## Timing

- Zero-wait-state bus: req sampled at edge E0 -> ADDR in cycle 1 -> DATA in cycle 2 -> done in cycle 3. That is 3 cycles from req to done.
- Each hready = 0 cycle in DATA or ADDR adds one cycle.
- Locally rejected request: done 1 cycle after the sampling edge.
- ERROR path: done is high in the cycle after the second ERROR cycle (hready = 1, hresp = 1).
- Bus no-op never overlaps local rejection: htrans stays IDLE throughout.
- A requester may drop req in its done cycle. A req still high when the FSM returns to IDLE is treated as a new request.
- Back-to-back transfers: minimum 4 cycles per transfer (DONE -> IDLE gap).

## Test plan

- Fetch 0xA000_0010, hrdata 0x1234_5678, no waits:
  - htrans NONSEQ in cycle 1, hsize 010, hprot 0000.
  - if_done in cycle 3 with if_rdata 0x1234_5678, if_err 0.
- LSU LB (func3 000) at 0xB000_0003, hrdata 0x80FF_FFFF -> ls_rdata 0xFFFF_FF80. Repeat with LBU (func3 100) -> 0x0000_0080.
- LSU SH (func3 001) to 0xB000_0002, ls_wdata 0x0000_ABCD, 2 wait states:
  - hwdata 0xABCD_ABCD, hsize 001, hwrite 1.
  - ls_done in cycle 5.
- Simultaneous if_req and ls_req twice in a row: LSU granted first, fetch second. Exactly one done pulse per transfer.
- Bus ERROR: DATA sees (hready 0, hresp 1) then (1, 1) -> htrans IDLE throughout, ls_done with ls_err 1.
- Local errors, each giving done + err 1 after 1 cycle with htrans never NONSEQ:
  - Store to 0xA000_0000.
  - Access to 0xC000_0000.
  - LW at 0xB000_0002.
- Additional reset check: assert hreset during DATA -> outputs at reset values, no done.
